// File: rtl/piso_pkg.sv
// piso_buf shared geometry, entry layout and lane mapping.
// Defaults describe the 64->16, two-word configuration.
package piso_pkg;
   localparam int DEF_IN_W  = 64;
   localparam int DEF_OUT_W = 16;
   localparam int DEF_DEPTH = 2;
   localparam int K         = DEF_IN_W / DEF_OUT_W;
   localparam int CNT_W     = $clog2(K + 1);
   localparam int LANE_W    = $clog2(K);
   localparam int PTR_W     = $clog2(DEF_DEPTH);

   typedef struct packed {
      logic                last;
      logic [CNT_W-1:0]    cnt;
      logic [DEF_IN_W-1:0] data;
   } entry_t;

   // emission-order lane index -> physical lane within the word
   function automatic int unsigned lane_sel(
      input int unsigned lane,
      input bit          lsb_first,
      input int unsigned k
   );
      return lsb_first ? lane : k - 1 - lane;
   endfunction
endpackage

// File: rtl/piso_word_fifo.sv
// piso_word_fifo: DEPTH-entry first-word-fall-through register FIFO.
// head always shows the oldest entry; caller never pushes when full.
module piso_word_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH+1)-1:0] occ
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (pop) rd_ptr <= nxt(rd_ptr);
         if (push && !pop)      occ <= occ + 1'b1;
         else if (pop && !push) occ <= occ - 1'b1;
      end
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/piso_buf.sv
// piso_buf: buffers wide words and emits them as narrow beats.
// Lane counter and lane mux sit on top of a FWFT word FIFO.
module piso_buf
   import piso_pkg::*;
#(
   parameter int DATA_IN_WIDTH  = DEF_IN_W,
   parameter int DATA_OUT_WIDTH = DEF_OUT_W,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int LSB_FIRST      = 1
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      IN_VLD,
   input  logic                      IN_LAST,
   input  logic [DATA_IN_WIDTH-1:0]  IN_DAT,
   input  logic [$clog2(DATA_IN_WIDTH/DATA_OUT_WIDTH+1)-1:0] IN_CNT,
   output logic                      IN_RDY,
   output logic [DATA_OUT_WIDTH-1:0] OUT_DAT,
   output logic                      OUT_VLD,
   output logic                      OUT_LAST,
   input  logic                      OUT_RDY
);
   localparam int LANES = DATA_IN_WIDTH / DATA_OUT_WIDTH;
   localparam int CNTW  = $clog2(LANES + 1);
   localparam int LANEW = $clog2(LANES);
   localparam int OCCW  = $clog2(DEPTH + 1);
   localparam int EW    = 1 + CNTW + DATA_IN_WIDTH;

   if (DATA_IN_WIDTH % DATA_OUT_WIDTH != 0 || LANES < 2) begin : g_bad_ratio
      $error("piso_buf: DATA_IN_WIDTH must be K*DATA_OUT_WIDTH, K >= 2");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("piso_buf: DEPTH must be >= 2");
   end

   typedef struct packed {
      logic                     last;
      logic [CNTW-1:0]          cnt;
      logic [DATA_IN_WIDTH-1:0] data;
   } word_t;

   word_t                     in_word;
   word_t                     head;
   logic [OCCW-1:0]           occ;
   logic [LANEW-1:0]          lane_q;
   logic [LANEW-1:0]          phys;
   logic [CNTW-1:0]           cnt_eff;
   logic                      final_lane;
   logic                      push;
   logic                      pop;
   logic                      word_pop;
   logic [DATA_OUT_WIDTH-1:0] lane_dat [LANES];

   // zero or out-of-range counts mean a full word
   always_comb begin
      cnt_eff = IN_CNT;
      if (IN_CNT == '0 || IN_CNT > CNTW'(LANES)) cnt_eff = CNTW'(LANES);
   end

   assign in_word = {IN_LAST, cnt_eff, IN_DAT};

   // RESET only masks; readiness otherwise comes from registered occupancy
   assign IN_RDY  = !RESET && (occ < OCCW'(DEPTH));
   assign OUT_VLD = !RESET && (occ != '0);

   assign push       = IN_VLD & IN_RDY;
   assign pop        = OUT_VLD & OUT_RDY;
   assign final_lane = CNTW'(lane_q) == head.cnt - CNTW'(1);
   assign word_pop   = pop & final_lane;
   assign OUT_LAST   = OUT_VLD & head.last & final_lane;

   assign phys = LANEW'(lane_sel(32'(lane_q), LSB_FIRST != 0, LANES));

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_dat[i] = head.data[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
   end

   assign OUT_DAT = RESET ? '0 : lane_dat[phys];

   always_ff @(posedge CLK) begin
      if (RESET)    lane_q <= '0;
      else if (pop) lane_q <= final_lane ? '0 : lane_q + 1'b1;
   end

   piso_word_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK      (CLK),
      .RESET    (RESET),
      .push     (push),
      .push_dat (in_word),
      .pop      (word_pop),
      .head     (head),
      .occ      (occ)
   );
endmodule
